// File: rtl/carry_add_scheduler.sv
// carry_add_scheduler: two requesters share one N/2-bit ripple adder.
// Each operation runs low half then high half, with the low carry folded
// into the upper half-sum by a separate increment step.
module carry_add_scheduler #(
    parameter int N  = 32,
    parameter int CW = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N:0]   resp_sum,
    output logic         resp_id,
    output logic [CW-1:0] op_count
);
    localparam int H = N / 2;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t       state;
    logic [N-1:0] a_q, b_q;
    logic         id_q;
    logic         ptr;
    logic [H-1:0] lo_q;
    logic         c0;

    // Grant: a lone requester wins; on contention the pointer decides.
    logic any_req, gnt1;
    assign any_req    = req0_valid | req1_valid;
    assign gnt1       = req1_valid & (~req0_valid | ptr);
    assign req0_ready = ~rst & (state == IDLE) & req0_valid & ~gnt1;
    assign req1_ready = ~rst & (state == IDLE) & gnt1;

    // Shared adder operand select: high halves only while in HIGH.
    logic [H-1:0] add_a, add_b;
    always_comb begin
        add_a = a_q[H-1:0];
        add_b = b_q[H-1:0];
        if (state == HIGH) begin
            add_a = a_q[N-1:H];
            add_b = b_q[N-1:H];
        end
    end

    // Shared N/2-bit ripple-carry adder, carry-in fixed at 0.
    logic [H:0]   rc;
    logic [H-1:0] add_s;
    always_comb begin
        rc    = '0;
        add_s = '0;
        for (int i = 0; i < H; i++) begin
            add_s[i]  = add_a[i] ^ add_b[i] ^ rc[i];
            rc[i+1]   = (add_a[i] & add_b[i]) | (rc[i] & (add_a[i] ^ add_b[i]));
        end
    end

    // Carry-increment: fold the low-half carry into the upper half-sum.
    logic [H:0] inc_s;
    assign inc_s = {1'b0, add_s} + {{H{1'b0}}, c0};

    // Sequencer: accept, low half, high half, then hold until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            lo_q       <= '0;
            c0         <= 1'b0;
            resp_valid <= 1'b0;
            resp_sum   <= '0;
            resp_id    <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        a_q   <= gnt1 ? req1_a : req0_a;
                        b_q   <= gnt1 ? req1_b : req0_b;
                        id_q  <= gnt1;
                        ptr   <= ~gnt1;
                        state <= LOW;
                    end
                end
                LOW: begin
                    lo_q  <= add_s;
                    c0    <= rc[H];
                    state <= HIGH;
                end
                HIGH: begin
                    resp_sum   <= {rc[H] | inc_s[H], inc_s[H-1:0], lo_q};
                    resp_id    <= id_q;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        op_count   <= op_count + CW'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_carry_add_scheduler.sv
// Scoreboard bench for carry_add_scheduler (N=32, CW=4).
module tb_carry_add_scheduler;
    localparam int N  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [N-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          req0_ready, req1_ready;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [N:0]    resp_sum;
    logic          resp_id;
    logic [CW-1:0] op_count;

    carry_add_scheduler #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sum(resp_sum), .resp_id(resp_id), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N:0] sum;
        logic       id;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: one operation in flight at a time.
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   busy = 0;
    bit   ptr = 0;
    int   cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        bit   g1, e0, e1;
        exp_t e;
        cyc++;
        if (rst) begin
            chk("ready0_in_reset", 64'(req0_ready), 64'd0);
            chk("ready1_in_reset", 64'(req1_ready), 64'd0);
            q.delete();
            busy = 0;
            ptr  = 0;
            cnt  = 0;
        end else begin
            g1 = req1_valid && (!req0_valid || ptr);
            e0 = !busy && req0_valid && !g1;
            e1 = !busy && g1;
            chk("req0_ready", 64'(req0_ready), 64'(e0));
            chk("req1_ready", 64'(req1_ready), 64'(e1));
            chk("resp_valid", 64'(resp_valid), 64'(busy && (cyc >= acc_cyc + 3)));
            chk("op_count", 64'(op_count), 64'(cnt % (1 << CW)));
            if (resp_valid && q.size() > 0) begin
                chk("resp_sum", 64'(resp_sum), 64'(q[0].sum));
                chk("resp_id", 64'(resp_id), 64'(q[0].id));
            end
            if (resp_valid && resp_ready && busy) begin
                void'(q.pop_front());
                cnt  = cnt + 1;
                busy = 0;
            end
            if (e0 || e1) begin
                e.id  = e1;
                e.sum = e1 ? ({1'b0, req1_a} + {1'b0, req1_b})
                           : ({1'b0, req0_a} + {1'b0, req0_b});
                q.push_back(e);
                busy    = 1;
                acc_cyc = cyc;
                ptr     = !e1;
            end
        end
    end

    // Present one operand pair on a requester until it is accepted.
    task automatic send(input bit who, input logic [N-1:0] a, input logic [N-1:0] b);
        bit got = 0;
        @(posedge clk); #1;
        if (who) begin req1_valid = 1; req1_a = a; req1_b = b; end
        else     begin req0_valid = 1; req0_a = a; req0_b = b; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = who ? req1_ready : req0_ready;
        end
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 0;
        req0_a = $urandom; req0_b = $urandom;
        req1_a = $urandom; req1_b = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
        if (busy) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Directed sums and carry chains.
        send(0, 32'h0000FFFF, 32'h00000001);
        wait_idle();
        chk("op_count_after_first", 64'(op_count), 64'd1);
        send(1, 32'hFFFFFFFF, 32'h00000001);
        wait_idle();
        send(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();
        send(1, 32'h00000000, 32'h00000000);
        wait_idle();

        // Contention from reset: grants alternate starting with requester 0.
        do_reset();
        req0_valid = 1; req1_valid = 1;
        req0_a = 32'h12345678; req0_b = 32'h9ABCDEF0;
        req1_a = 32'h80000000; req1_b = 32'h80000000;
        repeat (17) @(posedge clk);
        #1 req0_valid = 0; req1_valid = 0;
        wait_idle();

        // Backpressure: hold DONE for many cycles.
        resp_ready = 0;
        send(1, 32'hDEADBEEF, 32'h01234567);
        repeat (13) @(posedge clk);
        #1 resp_ready = 1;
        wait_idle();

        // Reset while the operation is in its high-half cycle.
        send(0, 32'hAAAAAAAA, 32'h55555556);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("valid_after_midreset", 64'(resp_valid), 64'd0);
        chk("count_after_midreset", 64'(op_count), 64'd0);
        req0_valid = 1; req1_valid = 1;
        req0_a = 32'h0F0F0F0F; req0_b = 32'hF0F0F0F1;
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
        wait_idle();

        // Randomized traffic with random backpressure; exceeds 16 ops so op_count wraps.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            req0_b = $urandom;
            req1_a = $urandom;
            req1_b = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            resp_ready = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0; resp_ready = 1;
        wait_idle();
        @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        chk("ops_completed_min", 64'(cnt >= 16), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
